// File: rtl/rr_encoder8.sv
// rr_encoder8: merges request bits into a pending set and streams round-robin granted indices over valid/ready.
module rr_encoder8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ready_in,
    output logic       valid_out,
    output logic [2:0] idx_out,
    output logic [7:0] pending,
    output logic       dup
);
    logic [7:0]  r_pending;
    logic        r_valid;
    logic [2:0]  r_idx;
    logic [2:0]  r_ptr;
    logic        r_dup;
    logic        w_load;
    logic        w_hit;
    logic [15:0] w_dbl;
    logic [7:0]  w_rot;
    logic [2:0]  w_off;
    logic [2:0]  w_k;
    logic [7:0]  w_clr;

    // Rotate so bit 0 is the pointer position; the lowest set bit is the round-robin winner.
    assign w_dbl  = {r_pending, r_pending} >> r_ptr;
    assign w_rot  = w_dbl[7:0];
    assign w_k    = r_ptr + w_off;
    assign w_hit  = |r_pending;
    assign w_load = !r_valid | ready_in;
    assign w_clr  = (w_load & w_hit) ? (8'b1 << w_k) : 8'h00;

    always_comb begin
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (w_rot[i]) w_off = 3'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 8'h00;
            r_valid   <= 1'b0;
            r_idx     <= 3'd0;
            r_ptr     <= 3'd0;
            r_dup     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | req;
            r_dup     <= |(req & r_pending & ~w_clr);
            if (w_load) begin
                r_valid <= w_hit;
                if (w_hit) begin
                    r_idx <= w_k;
                    r_ptr <= w_k + 3'd1;
                end
            end
        end
    end

    assign valid_out = r_valid;
    assign idx_out   = r_idx;
    assign pending   = r_pending;
    assign dup       = r_dup;
endmodule

// File: tb/tb_rr_encoder8.sv
// tb_rr_encoder8: directed and random checks of rr_encoder8 against a behavioural scan model.
module tb_rr_encoder8;
    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready_in;
    logic       valid_out;
    logic [2:0] idx_out;
    logic [7:0] pending;
    logic       dup;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_pend;
    bit         m_valid;
    logic [2:0] m_idx;
    int         m_ptr;
    bit         m_dup;

    rr_encoder8 dut (
        .clk(clk), .rst(rst), .req(req), .ready_in(ready_in),
        .valid_out(valid_out), .idx_out(idx_out), .pending(pending), .dup(dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_valid"}, {7'd0, valid_out}, {7'd0, m_valid});
        chk({tag, "_idx"}, {5'd0, idx_out}, {5'd0, m_idx});
        chk({tag, "_pending"}, pending, m_pend);
        chk({tag, "_dup"}, {7'd0, dup}, {7'd0, m_dup});
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_valid = 0; m_idx = 3'd0; m_ptr = 0; m_dup = 0;
    endtask

    // Grant rule: first pending index found walking up from ptr, wrapping modulo 8.
    task automatic model_step(input logic [7:0] r, input bit rd);
        bit ld;
        bit hit;
        int k;
        logic [7:0] clr;
        ld = !m_valid || rd;
        hit = m_pend != 8'h00;
        k = -1;
        for (int j = 0; j < 8; j++)
            if (k < 0 && m_pend[(m_ptr + j) % 8]) k = (m_ptr + j) % 8;
        clr = 8'h00;
        if (ld && hit) clr[k] = 1'b1;
        m_dup = |(r & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | r;
        if (ld) begin
            m_valid = hit;
            if (hit) begin
                m_idx = 3'(k);
                m_ptr = (k + 1) % 8;
            end
        end
    endtask

    task automatic cycle(input string tag, input logic [7:0] r, input bit rd);
        req = r;
        ready_in = rd;
        @(posedge clk);
        model_step(r, rd);
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #2;
        chk_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req = 8'h00;
        ready_in = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        chk_all("por");
        // Reset mid-handshake with a held index and pending=0F
        cycle("t1a", 8'h01, 0);
        cycle("t1b", 8'h0F, 0);
        chk("t1_pend0F", pending, 8'h0F);
        chk("t1_valid1", {7'd0, valid_out}, 8'd1);
        do_reset("t1_rst");
        for (int i = 0; i < 3; i++) cycle("t1_idle", 8'h00, 1);
        // Single request latency
        cycle("t2a", 8'h20, 1);
        chk("t2_pend", pending, 8'h20);
        cycle("t2b", 8'h00, 1);
        chk("t2_idx5", {5'd0, idx_out}, 8'd5);
        cycle("t2c", 8'h00, 1);
        // Full drain then wrap
        do_reset("t3_rst");
        cycle("t3a", 8'hFF, 1);
        for (int i = 0; i < 8; i++) begin
            cycle("t3_drain", 8'h00, 1);
            chk("t3_seq", {5'd0, idx_out}, 8'(i));
        end
        cycle("t3_empty", 8'h00, 1);
        cycle("t3_81", 8'h81, 1);
        cycle("t3_g0", 8'h00, 1);
        chk("t3_first0", {5'd0, idx_out}, 8'd0);
        cycle("t3_g7", 8'h00, 1);
        chk("t3_then7", {5'd0, idx_out}, 8'd7);
        cycle("t3_end", 8'h00, 1);
        // Backpressure
        do_reset("t4_rst");
        cycle("t4a", 8'h06, 1);
        cycle("t4b", 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("t4_hold", 8'h00, 0);
            chk("t4_idx1", {5'd0, idx_out}, 8'd1);
            chk("t4_pend04", pending, 8'h04);
        end
        cycle("t4_go", 8'h00, 1);
        chk("t4_idx2", {5'd0, idx_out}, 8'd2);
        cycle("t4_end", 8'h00, 1);
        // Set wins over clear
        do_reset("t5_rst");
        cycle("t5a", 8'h08, 1);
        cycle("t5b", 8'h08, 1);
        chk("t5_pend08", pending, 8'h08);
        chk("t5_dup0", {7'd0, dup}, 8'd0);
        cycle("t5c", 8'h00, 1);
        chk("t5_again3", {5'd0, idx_out}, 8'd3);
        cycle("t5d", 8'h00, 1);
        // Duplicate merge
        do_reset("t6_rst");
        cycle("t6a", 8'h01, 0);
        cycle("t6b", 8'h10, 0);
        cycle("t6c", 8'h10, 0);
        chk("t6_dup1", {7'd0, dup}, 8'd1);
        cycle("t6d", 8'h00, 0);
        chk("t6_dup0", {7'd0, dup}, 8'd0);
        for (int i = 0; i < 4; i++) cycle("t6_drain", 8'h00, 1);
        // Random traffic with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rnd_rst");
            cycle("rnd", ($urandom % 3 == 0) ? 8'($urandom) : 8'h00, ($urandom % 4) != 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
